simon_game_ctrl: RTL and testbench
==================================

// Module: simon_game_ctrl
// PURPOSE
//  Round sequencer for the Simon Says datapath. Owns the 32-entry segment store and appends one
//  random symbol per round. Plays the sequence back on the lamps, then steps check_round through
//  the stored entries while the player presses buttons. Uses verify_input's result/empty
//  (combinational) to decide pass, lose or win. Sits between the button synchroniser/LFSR and the
//  lamp/score display.
// PARAMETERS
//  DEPTH          32          max sequence length; check_round width = $clog2(DEPTH) = 5
//  STEP_CYCLES    25_000_000  cycles a lamp stays lit during playback
//  GAP_CYCLES     12_500_000  dark cycles between playback steps
//  TIMEOUT_CYCLES 100_000_000 max cycles waiting for a press before loss
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       synchronous, active-low reset
//  start        in   1       1-cycle pulse; honoured only in IDLE, LOSE or WIN
//  rand_sym     in   2       random symbol 0..3 from external LFSR, sampled in APPEND
//  buttons      in   4       synchronised, debounced, active-high; bit3 = symbol 3 ... bit0 = symbol 0
//  segment      out  3x32    segment store to verify_input; 3'b1xx = empty, 3'b0ss = symbol ss
//  player_input out  4       captured press to verify_input; 0 outside CHECK
//  check_round  out  5       index under test to verify_input
//  result       in   1       verify_input: segment[check_round] == encoded player_input
//  empty        in   1       verify_input: segment[check_round][2]
//  lamp         out  4       one-hot lamp drive (same bit order as buttons)
//  score        out  6       rounds completed (0..DEPTH)
//  busy         out  1       high outside IDLE, LOSE and WIN
//  game_over    out  1       high in LOSE
//  win          out  1       high in WIN
// BEHAVIOUR
//  Reset: every segment = 3'b100; length, idx, check_round, score, lamp, player_input = 0;
//   busy, game_over, win = 0; state = IDLE. All outputs are registered.
//  Symbol encoding: sym s is stored as {1'b0,s}; lamp/press one-hot = 1<<s.
//  States and transitions:
//   IDLE: on start, clear all segments to 3'b100, set length=0 and score=0 -> APPEND.
//   APPEND: segment[length] <= {0,rand_sym}; length++; idx=0 -> SHOW_ON.
//   SHOW_ON: lamp = onehot(segment[idx]) for STEP_CYCLES cycles -> SHOW_OFF.
//   SHOW_OFF: lamp = 0 for GAP_CYCLES cycles; idx++. If idx == length: idx = 0 -> WAIT_PRESS.
//    Otherwise -> SHOW_ON.
//   WAIT_PRESS: check_round = idx; timeout timer reloads on entry.
//    On the first cycle with buttons != 0: latch buttons into player_input -> CHECK.
//    If the timer expires first -> LOSE.
//   CHECK (exactly 1 cycle): if empty -> LOSE (store corruption). Else if !result -> LOSE.
//    Else: lamp = player_input (echo) -> WAIT_RELEASE.
//   WAIT_RELEASE: hold the echo until buttons == 0, then clear lamp and player_input; idx++.
//    If idx == length: score = length; -> WIN if length == DEPTH, else -> APPEND.
//    Otherwise -> WAIT_PRESS.
//   LOSE / WIN: lamps off, hold; start -> same path as start in IDLE.
//  Press decision: made in the CHECK cycle, 1 cycle after the press is seen.
//  Multi-hot press: verify_input encodes it as 3'b100, which mismatches -> LOSE. No priority pick.
//  Buttons still held on entry to WAIT_PRESS: they count as a press. The WAIT_RELEASE gate
//   prevents a single hold from being reused across entries.
//  start during busy states: ignored. rst_n low mid-game: full reset on that edge.
//  rand_sym is sampled only in APPEND; its value at other times is don't-care.
//  Timers: down-counters load N-1 and expire at 0, so a phase lasts exactly N cycles.
//  length never exceeds DEPTH; idx and check_round never index beyond length-1.
// STRUCTURE
//  simon_pkg: state enum, SYM_EMPTY = 3'b100, function sym2onehot(2-bit) -> 4-bit, DEPTH_W.
//  Sub-module simon_phase_timer: load/count/expire down-counter, width $clog2 of the largest
//   parameter. Used for the show, gap and timeout phases.
//  Segment store: a 3x32 register array in this module (reset-able), not RAM.
// TESTING  (bench: STEP_CYCLES=2, GAP_CYCLES=1, TIMEOUT_CYCLES=20, real verify_input instance)
//  1. Reset, then start with rand_sym=2 -> segment[0]=3'b010, lamp=4'b0100 for 2 cycles, then 0.
//     Then WAIT_PRESS with check_round=0.
//  2. Round 1: press buttons=4'b0100, then release.
//     -> score=1, APPEND; round 2 replays segment[0] then segment[1].
//  3. Wrong press 4'b0001 against stored 3'b010 -> game_over=1 the cycle after CHECK.
//     busy=0, lamp=0, score unchanged.
//  4. Multi-hot press 4'b0110 -> LOSE. No press for 20 cycles in WAIT_PRESS -> LOSE.
//  5. Force 32 correct rounds -> win=1, score=32, no 33rd APPEND. start -> score=0 and all
//     segments 3'b100 for one cycle, then segment[0] is written.
//  6. rst_n=0 during SHOW_ON of round 3 -> next cycle all outputs at reset values.
//     start pulses while busy change nothing.

Source files
------------

// File: rtl/simon_game_ctrl_pkg.sv
// Shared types and helpers for the Simon round sequencer.
package simon_game_ctrl_pkg;

  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned DEPTH_W   = $clog2(DEPTH_DEF);

  // Store encoding: 3'b1xx marks an unused slot, 3'b0ss holds symbol ss.
  localparam logic [2:0] SYM_EMPTY = 3'b100;

  typedef enum logic [3:0] {
    StIdle,
    StAppend,
    StShowOn,
    StShowOff,
    StWaitPress,
    StCheck,
    StWaitRelease,
    StLose,
    StWin
  } state_e;

  function automatic logic [3:0] sym2onehot(input logic [1:0] sym);
    return 4'b0001 << sym;
  endfunction

endpackage

// File: rtl/simon_game_ctrl_if.sv
// Link between the round sequencer and the verify_input comparator.
interface simon_game_ctrl_if #(
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [DEPTH-1:0][2:0] segment;
  logic [3:0]            player_input;
  logic [IdxW-1:0]       check_round;
  logic                  result;
  logic                  empty;

  modport master (
    output segment,
    output player_input,
    output check_round,
    input  result,
    input  empty
  );

  modport slave (
    input  segment,
    input  player_input,
    input  check_round,
    output result,
    output empty
  );
endinterface

// File: rtl/simon_game_ctrl_phase_timer.sv
// Load/count/expire down-counter; a load of N-1 gives a phase of exactly N cycles.
module simon_game_ctrl_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Reload takes priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon Says round sequencer: grows the sequence, plays it back, checks player presses.
module simon_game_ctrl
  import simon_game_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH          = DEPTH_DEF,
  parameter int unsigned STEP_CYCLES    = 25_000_000,
  parameter int unsigned GAP_CYCLES     = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [1:0]                 rand_sym,
  input  logic [3:0]                 buttons,
  simon_game_ctrl_if.master          vif,
  output logic [3:0]                 lamp,
  output logic [$clog2(DEPTH+1)-1:0] score,
  output logic                       busy,
  output logic                       game_over,
  output logic                       win
);

  localparam int unsigned IdxW   = $clog2(DEPTH);
  localparam int unsigned LenW   = $clog2(DEPTH + 1);
  localparam int unsigned MaxA   = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCyc = (MaxA > TIMEOUT_CYCLES) ? MaxA : TIMEOUT_CYCLES;
  localparam int unsigned TW     = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [TW-1:0] StepLd = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] GapLd  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] ToutLd = TW'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [DEPTH-1:0][2:0] seg_q, seg_d;
  logic [LenW-1:0]       len_q, len_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [IdxW-1:0]       cr_q, cr_d;
  logic [LenW-1:0]       score_q, score_d;
  logic [3:0]            lamp_q, lamp_d;
  logic [3:0]            pin_q, pin_d;
  logic                  busy_q, busy_d;
  logic                  over_q, over_d;
  logic                  win_q, win_d;

  logic                  tmr_load;
  logic [TW-1:0]         tmr_val;
  logic                  tmr_expired;
  logic [LenW-1:0]       idx_inc;

  // One timer serves show, gap and press-timeout phases; each entry reloads it.
  simon_game_ctrl_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // Next-state and registered-output decode for the round FSM.
  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cr_d     = cr_q;
    score_d  = score_q;
    lamp_d   = lamp_q;
    pin_d    = pin_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    idx_inc  = LenW'(idx_q) + LenW'(1);

    unique case (state_q)
      StIdle, StLose, StWin: begin
        lamp_d = '0;
        pin_d  = '0;
        if (start) begin
          seg_d   = {DEPTH{SYM_EMPTY}};
          len_d   = '0;
          score_d = '0;
          idx_d   = '0;
          cr_d    = '0;
          state_d = StAppend;
        end
      end
      StAppend: begin
        seg_d[len_q[IdxW-1:0]] = {1'b0, rand_sym};
        len_d    = len_q + LenW'(1);
        idx_d    = '0;
        // Slot 0 may be the one written this cycle, so read the updated store.
        lamp_d   = sym2onehot(seg_d[0][1:0]);
        tmr_load = 1'b1;
        tmr_val  = StepLd;
        state_d  = StShowOn;
      end
      StShowOn: begin
        if (tmr_expired) begin
          lamp_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = GapLd;
          state_d  = StShowOff;
        end
      end
      StShowOff: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          if (idx_inc == len_q) begin
            idx_d   = '0;
            cr_d    = '0;
            tmr_val = ToutLd;
            state_d = StWaitPress;
          end else begin
            idx_d   = idx_inc[IdxW-1:0];
            lamp_d  = sym2onehot(seg_q[idx_inc[IdxW-1:0]][1:0]);
            tmr_val = StepLd;
            state_d = StShowOn;
          end
        end
      end
      StWaitPress: begin
        // A press seen on the final timeout cycle still counts.
        if (buttons != 4'b0000) begin
          pin_d   = buttons;
          state_d = StCheck;
        end else if (tmr_expired) begin
          state_d = StLose;
        end
      end
      StCheck: begin
        if (vif.empty || !vif.result) begin
          pin_d   = '0;
          state_d = StLose;
        end else begin
          lamp_d  = pin_q;
          state_d = StWaitRelease;
        end
      end
      StWaitRelease: begin
        if (buttons == 4'b0000) begin
          lamp_d = '0;
          pin_d  = '0;
          if (idx_inc == len_q) begin
            score_d = len_q;
            state_d = (len_q == LenW'(DEPTH)) ? StWin : StAppend;
          end else begin
            idx_d    = idx_inc[IdxW-1:0];
            cr_d     = idx_inc[IdxW-1:0];
            tmr_load = 1'b1;
            tmr_val  = ToutLd;
            state_d  = StWaitPress;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = !(state_d inside {StIdle, StLose, StWin});
    over_d = (state_d == StLose);
    win_d  = (state_d == StWin);
  end

  // State, store and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      seg_q   <= {DEPTH{SYM_EMPTY}};
      len_q   <= '0;
      idx_q   <= '0;
      cr_q    <= '0;
      score_q <= '0;
      lamp_q  <= '0;
      pin_q   <= '0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cr_q    <= cr_d;
      score_q <= score_d;
      lamp_q  <= lamp_d;
      pin_q   <= pin_d;
      busy_q  <= busy_d;
      over_q  <= over_d;
      win_q   <= win_d;
    end
  end

  assign vif.segment      = seg_q;
  assign vif.player_input = pin_q;
  assign vif.check_round  = cr_q;
  assign lamp             = lamp_q;
  assign score            = score_q;
  assign busy             = busy_q;
  assign game_over        = over_q;
  assign win              = win_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Randomised bench for simon_game_ctrl: plays games against a sequence-level model.
module tb_simon_game_ctrl;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned STEP  = 2;
  localparam int unsigned GAP   = 1;
  localparam int unsigned TOUT  = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] rand_sym;
  logic [3:0] buttons;
  logic [3:0] lamp;
  logic [5:0] score;
  logic       busy;
  logic       game_over;
  logic       win;

  simon_game_ctrl_if #(.DEPTH(DEPTH)) bus ();

  simon_game_ctrl #(
    .DEPTH          (DEPTH),
    .STEP_CYCLES    (STEP),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rand_sym  (rand_sym),
    .buttons   (buttons),
    .vif       (bus),
    .lamp      (lamp),
    .score     (score),
    .busy      (busy),
    .game_over (game_over),
    .win       (win)
  );

  always #5 clk = ~clk;

  // verify_input: combinational compare of the stored slot with the encoded press.
  logic [2:0] enc;
  always_comb begin
    case (bus.player_input)
      4'b0001: enc = 3'b000;
      4'b0010: enc = 3'b001;
      4'b0100: enc = 3'b010;
      4'b1000: enc = 3'b011;
      default: enc = 3'b100;
    endcase
    bus.result = (bus.segment[bus.check_round] == enc);
    bus.empty  = bus.segment[bus.check_round][2];
  end

  int         n_total = 0;
  int         n_bad   = 0;
  logic [1:0] seq[$];
  int         score_exp;
  bit         ok;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] s);
    logic [3:0] v;
    v = 4'b0001 << s;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Start is ignored while busy, so it is toggled freely in busy states.
  task automatic noise();
    start    = 1'($urandom_range(0, 1));
    rand_sym = 2'($urandom_range(0, 3));
  endtask

  task automatic check_seg(input string tag);
    logic [DEPTH-1:0][2:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      e[i] = (i < seq.size()) ? {1'b0, seq[i]} : 3'b100;
    end
    check_eq(tag, 128'(bus.segment), 128'(e));
  endtask

  task automatic check_reset_vals(input string tag);
    seq.delete();
    check_eq({tag, "_lamp"}, 128'(lamp), 128'(0));
    check_eq({tag, "_score"}, 128'(score), 128'(0));
    check_eq({tag, "_busy"}, 128'(busy), 128'(0));
    check_eq({tag, "_over"}, 128'(game_over), 128'(0));
    check_eq({tag, "_win"}, 128'(win), 128'(0));
    check_eq({tag, "_pin"}, 128'(bus.player_input), 128'(0));
    check_eq({tag, "_cr"}, 128'(bus.check_round), 128'(0));
    check_seg({tag, "_seg"});
  endtask

  // Called on a negedge while idle/lose/win; returns on the APPEND-cycle negedge.
  task automatic begin_game();
    start = 1'b1;
    step();
    start = 1'b0;
    seq.delete();
    score_exp = 0;
    check_eq("bg_busy", 128'(busy), 128'(1));
    check_eq("bg_lamp", 128'(lamp), 128'(0));
    check_eq("bg_score", 128'(score), 128'(0));
    check_eq("bg_over", 128'(game_over), 128'(0));
    check_eq("bg_win", 128'(win), 128'(0));
    check_seg("bg_seg_clear");
  endtask

  // Called on the APPEND negedge; returns on the first WAIT_PRESS negedge.
  task automatic show_round();
    logic [1:0] r;
    r = 2'($urandom_range(0, 3));
    start    = 1'($urandom_range(0, 1));
    rand_sym = r;
    seq.push_back(r);
    foreach (seq[i]) begin
      repeat (STEP) begin
        step();
        check_eq("show_lamp", 128'(lamp), 128'(onehot(seq[i])));
        if (i == 0) check_seg("append_wr");
        noise();
      end
      repeat (GAP) begin
        step();
        check_eq("gap_lamp", 128'(lamp), 128'(0));
        noise();
      end
    end
    step();
    check_eq("wait_cr", 128'(bus.check_round), 128'(0));
    check_eq("wait_lamp", 128'(lamp), 128'(0));
    check_eq("wait_busy", 128'(busy), 128'(1));
  endtask

  // Called on a WAIT_PRESS negedge for entry i.
  task automatic press(input int i, input logic [3:0] p, output bit good);
    buttons = p;
    noise();
    step();
    check_eq("chk_pin", 128'(bus.player_input), 128'(p));
    check_eq("chk_lamp", 128'(lamp), 128'(0));
    good = (p == onehot(seq[i]));
    noise();
    step();
    if (!good) begin
      check_eq("lose_over", 128'(game_over), 128'(1));
      check_eq("lose_busy", 128'(busy), 128'(0));
      check_eq("lose_lamp", 128'(lamp), 128'(0));
      check_eq("lose_win", 128'(win), 128'(0));
      check_eq("lose_score", 128'(score), 128'(score_exp));
      start   = 1'b0;
      buttons = '0;
    end else begin
      check_eq("echo_lamp", 128'(lamp), 128'(p));
      repeat ($urandom_range(0, 2)) begin
        noise();
        step();
        check_eq("hold_lamp", 128'(lamp), 128'(p));
      end
      buttons = '0;
      noise();
      step();
      check_eq("rel_lamp", 128'(lamp), 128'(0));
      check_eq("rel_pin", 128'(bus.player_input), 128'(0));
      if (i == seq.size() - 1) begin
        score_exp = seq.size();
        check_eq("round_score", 128'(score), 128'(score_exp));
        if (seq.size() == DEPTH) begin
          check_eq("win_flag", 128'(win), 128'(1));
          check_eq("win_busy", 128'(busy), 128'(0));
          start = 1'b0;
        end else begin
          check_eq("next_busy", 128'(busy), 128'(1));
          check_eq("next_win", 128'(win), 128'(0));
        end
      end else begin
        check_eq("next_cr", 128'(bus.check_round), 128'(i + 1));
        check_eq("next_busy", 128'(busy), 128'(1));
      end
    end
  endtask

  task automatic play_correct_round();
    bit g;
    show_round();
    for (int i = 0; i < seq.size(); i++) begin
      press(i, onehot(seq[i]), g);
    end
  endtask

  initial begin
    logic [1:0] ws;
    logic [3:0] multi[8];
    multi = '{4'b0011, 4'b0110, 4'b1100, 4'b1010, 4'b0101, 4'b1001, 4'b0111, 4'b1111};

    rst_n    = 1'b0;
    start    = 1'b0;
    rand_sym = '0;
    buttons  = '0;
    step();
    step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();
    check_reset_vals("idle");

    // Two good rounds, then a wrong one-hot press on entry 1 of round 3.
    begin_game();
    play_correct_round();
    play_correct_round();
    show_round();
    press(0, onehot(seq[0]), ok);
    ws = seq[1] + 2'($urandom_range(1, 3));
    press(1, onehot(ws), ok);

    // Multi-hot press never matches.
    begin_game();
    play_correct_round();
    show_round();
    press(0, multi[$urandom_range(0, 7)], ok);

    // No press for the full timeout window.
    begin_game();
    show_round();
    start = 1'b0;
    repeat (TOUT - 1) step();
    check_eq("tout_not_yet", 128'(game_over), 128'(0));
    check_eq("tout_busy", 128'(busy), 128'(1));
    step();
    check_eq("tout_over", 128'(game_over), 128'(1));
    check_eq("tout_idle", 128'(busy), 128'(0));
    check_eq("tout_lamp", 128'(lamp), 128'(0));

    // Full game up to DEPTH rounds.
    begin_game();
    repeat (DEPTH) play_correct_round();
    repeat (3) begin
      step();
      check_eq("win_hold", 128'(win), 128'(1));
      check_eq("win_hold_busy", 128'(busy), 128'(0));
      check_eq("win_hold_score", 128'(score), 128'(DEPTH));
    end

    // Restart from WIN, then reset in the middle of round 3 playback.
    begin_game();
    play_correct_round();
    play_correct_round();
    rand_sym = 2'($urandom_range(0, 3));
    start    = 1'b0;
    step();
    check_eq("r3_show", 128'(lamp), 128'(onehot(seq[0])));
    rst_n = 1'b0;
    start = 1'b1;
    step();
    check_reset_vals("midreset");
    rst_n = 1'b1;
    start = 1'b0;
    step();
    check_reset_vals("post_reset");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
